// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: address/control sequencer that steps a shared MAC through an N-tap FIR per sample.
module fir_mac_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int MAC_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sample_valid_in,
    output logic              ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [ADDR_W-1:0] coef_addr_out,
    output logic              mac_valid_out,
    output logic              mac_first_out,
    output logic              data_ready_out,
    output logic              overrun_out,
    output logic              busy_out
);
    typedef enum logic [1:0] {IDLE, WRITE, MAC, DRAIN} state_t;
    localparam logic [3:0] LAST_DRAIN = 4'(MAC_LATENCY - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_head, r_k, r_wr_addr, r_rd_addr, r_coef_addr;
    logic [3:0]        r_cnt;
    logic              r_ready, r_wr_en, r_mac_valid, r_mac_first, r_data_ready, r_overrun, r_busy;

    // Outputs are computed one edge ahead so each register holds the value for the state being entered.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_head       <= '0;
            r_k          <= '0;
            r_cnt        <= '0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_coef_addr  <= '0;
            r_ready      <= 1'b1;
            r_wr_en      <= 1'b0;
            r_mac_valid  <= 1'b0;
            r_mac_first  <= 1'b0;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (sample_valid_in && r_state != IDLE) r_overrun <= 1'b1;
            case (r_state)
                IDLE: if (sample_valid_in) begin
                    r_state   <= WRITE;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b1;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_head;
                end
                WRITE: begin
                    r_state     <= MAC;
                    r_wr_en     <= 1'b0;
                    r_k         <= '0;
                    r_mac_valid <= 1'b1;
                    r_mac_first <= 1'b1;
                    r_coef_addr <= '0;
                    r_rd_addr   <= r_head;
                end
                MAC: begin
                    r_mac_first <= 1'b0;
                    if (&r_k) begin
                        r_state      <= DRAIN;
                        r_mac_valid  <= 1'b0;
                        r_cnt        <= '0;
                        r_data_ready <= (LAST_DRAIN == '0);
                    end else begin
                        r_k         <= r_k + 1'b1;
                        r_coef_addr <= r_k + 1'b1;
                        r_rd_addr   <= r_head - r_k - 1'b1;
                    end
                end
                DRAIN: if (r_data_ready) begin
                    r_state      <= IDLE;
                    r_data_ready <= 1'b0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_head       <= r_head + 1'b1;
                end else begin
                    r_cnt        <= r_cnt + 1'b1;
                    r_data_ready <= (r_cnt + 1'b1 == LAST_DRAIN);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_out      = r_ready;
    assign wr_en_out      = r_wr_en;
    assign wr_addr_out    = r_wr_addr;
    assign rd_addr_out    = r_rd_addr;
    assign coef_addr_out  = r_coef_addr;
    assign mac_valid_out  = r_mac_valid;
    assign mac_first_out  = r_mac_first;
    assign data_ready_out = r_data_ready;
    assign overrun_out    = r_overrun;
    assign busy_out       = r_busy;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed self-checking bench for fir_mac_sequencer with default parameters.
module tb_fir_mac_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       ready, wr_en, mac_valid, mac_first, data_ready, overrun, busy;
    logic [4:0] wr_addr, rd_addr, coef_addr;
    int         checks = 0;
    int         errors = 0;

    wire [6:0]  w_flags = {ready, wr_en, mac_valid, mac_first, data_ready, overrun, busy};
    wire [21:0] w_all   = {w_flags, wr_addr, rd_addr, coef_addr};
    localparam logic [21:0] RESET_ALL = {7'b1000000, 15'd0};

    fir_mac_sequencer dut (
        .clk_in(clk), .rst_in(rst_n), .sample_valid_in(valid),
        .ready_out(ready), .wr_en_out(wr_en), .wr_addr_out(wr_addr),
        .rd_addr_out(rd_addr), .coef_addr_out(coef_addr),
        .mac_valid_out(mac_valid), .mac_first_out(mac_first),
        .data_ready_out(data_ready), .overrun_out(overrun), .busy_out(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full accepted sample, checked cycle by cycle from wr_en through the return to IDLE.
    task automatic do_sample(input logic [4:0] h, input logic ov);
        logic [12:0] exp_tap;
        logic [4:0]  kk;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("wr", {wr_en, wr_addr}, {1'b1, h});
        chk("flags_wr", w_flags, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ov, 1'b1});
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            kk = k[4:0];
            exp_tap = {1'b1, kk == 5'd0, 1'b0, kk, h - kk};
            chk("tap", {mac_valid, mac_first, wr_en, coef_addr, rd_addr}, exp_tap);
        end
        @(negedge clk);
        chk("drain", w_flags, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ov, 1'b1});
        @(negedge clk);
        chk("data_ready", w_flags, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ov, 1'b1});
        @(negedge clk);
        chk("back_idle", w_flags, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ov, 1'b0});
    endtask

    // Strobe at index 0 plus optional extra strobes at s2/s3; records pulses over n cycles.
    task automatic observe(input int n, input int s2, input int s3,
                           output int dr_cnt, output int dr_at, output int wr_cnt,
                           output int wr_at, output logic [4:0] wr_a,
                           output logic ov34, output logic ov36);
        dr_cnt = 0; dr_at = -1; wr_cnt = 0; wr_at = -1; wr_a = '0; ov34 = 1'bx; ov36 = 1'bx;
        @(negedge clk);
        valid = 1'b1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (data_ready) begin
                dr_cnt++;
                if (dr_cnt == 1) dr_at = j;
            end
            if (wr_en) begin
                wr_cnt++;
                wr_at = j;
                wr_a = wr_addr;
            end
            if (j == 34) ov34 = overrun;
            if (j == 36) ov36 = overrun;
            valid = (j == s2) || (j == s3);
        end
        valid = 1'b0;
    endtask

    initial begin
        int dr_cnt, dr_at, wr_cnt, wr_at, bad;
        logic [4:0] wr_a;
        logic ov34, ov36;
        repeat (3) @(negedge clk);
        chk("in_reset", w_all, RESET_ALL);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (w_all !== RESET_ALL) bad++;
        end
        chk("idle_100", bad, 0);

        for (int i = 0; i < 33; i++) begin
            do_sample(5'(i % 32), 1'b0);
            repeat (50) @(negedge clk);
        end

        observe(40, 10, -1, dr_cnt, dr_at, wr_cnt, wr_at, wr_a, ov34, ov36);
        chk("ovr_dr_cnt", dr_cnt, 1);
        chk("ovr_dr_at", dr_at, 35);
        chk("ovr_wr_cnt", wr_cnt, 1);
        chk("ovr_wr_addr", wr_a, 5'd1);
        chk("ovr_set", ov34, 1'b1);
        repeat (20) @(negedge clk);
        chk("ovr_sticky", {overrun, ready}, 2'b11);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_clears_ovr", w_all, RESET_ALL);
        rst_n = 1'b1;
        observe(75, 35, 36, dr_cnt, dr_at, wr_cnt, wr_at, wr_a, ov34, ov36);
        chk("edge_ov_before", ov34, 1'b0);
        chk("edge_ov_after", ov36, 1'b1);
        chk("edge_wr_cnt", wr_cnt, 2);
        chk("edge_wr_at", wr_at, 37);
        chk("edge_wr_addr", wr_a, 5'd1);
        chk("edge_dr_cnt", dr_cnt, 2);
        chk("edge_dr_at", dr_at, 35);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        valid = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        chk("tap15", {mac_valid, coef_addr, rd_addr}, {1'b1, 5'd15, 5'd17});
        rst_n = 1'b0;
        #1;
        chk("async_rst", w_all, RESET_ALL);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no_dr_after_rst", bad, 0);
        do_sample(5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
